// File: rtl/cs_req_scheduler.sv
// Round-robin front end for the computational-storage command port: clears the
// array after reset, then issues one requester command per cycle and routes read returns.
module cs_req_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addA,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addB,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addC,
  input  logic [DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [1:0]                 cs_cmd,
  output logic [ADDR_W-1:0]          cs_addA,
  output logic [ADDR_W-1:0]          cs_addB,
  output logic [ADDR_W-1:0]          cs_addC,
  output logic [DATA_W-1:0]          cs_dq_out,
  output logic                       cs_dq_oe,
  input  logic [DATA_W-1:0]          cs_dq_in,
  output logic                       busy
);

  localparam int ID_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [1:0] OP_RD = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic                accept;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_a, sel_b, sel_c;
  logic [DATA_W-1:0]   sel_wdata;
  logic                tag_vld_p [0:RD_LAT];
  logic [ID_W-1:0]     tag_id_p  [0:RD_LAT];

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (id == ID_W'(i)) v[i] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    case (state)
      ST_INIT: begin
        busy    = 1'b1;
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST_ADDR) state_nxt = ST_RUN;
      end
      default: ;
    endcase
  end

  // Arbitration: first valid requester at or after rr_ptr, with wrap
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_inc(rr_ptr, k);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // reset is folded in so the grant is withheld while reset is held, whatever the state
  assign accept    = grant_vld && (state == ST_RUN) && reset;
  assign req_ready = accept ? id_onehot(grant_id) : '0;

  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_c     = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_op    = req_op[2*i +: 2];
        sel_a     = req_addA[ADDR_W*i +: ADDR_W];
        sel_b     = req_addB[ADDR_W*i +: ADDR_W];
        sel_c     = req_addC[ADDR_W*i +: ADDR_W];
        sel_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else if (accept) rr_ptr <= wrap_inc(grant_id, 1);
  end

  // Stage p0: command register toward storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_cmd    <= '0;
      cs_addA   <= '0;
      cs_addB   <= '0;
      cs_addC   <= '0;
      cs_dq_out <= '0;
      cs_dq_oe  <= 1'b0;
    end else if (state == ST_INIT) begin
      cs_cmd    <= OP_WR;
      cs_addA   <= '0;
      cs_addB   <= '0;
      cs_addC   <= cnt;
      cs_dq_out <= '0;
      cs_dq_oe  <= 1'b1;
    end else if (accept) begin
      cs_cmd    <= sel_op;
      cs_addA   <= sel_a;
      cs_addB   <= sel_b;
      cs_addC   <= sel_c;
      cs_dq_out <= (sel_op == OP_WR) ? sel_wdata : '0;
      cs_dq_oe  <= (sel_op == OP_WR);
    end else begin
      cs_cmd    <= OP_RD;
      cs_addA   <= '0;
      cs_addB   <= '0;
      cs_addC   <= '0;
      cs_dq_out <= '0;
      cs_dq_oe  <= 1'b0;
    end
  end

  // Stages p0..pRD_LAT: read tag follows the command until storage data is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_vld_p[k] <= 1'b0;
        tag_id_p[k]  <= '0;
      end
    end else begin
      tag_vld_p[0] <= accept && (sel_op == OP_RD);
      tag_id_p[0]  <= grant_id;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
        tag_id_p[k]  <= tag_id_p[k-1];
      end
    end
  end

  // Response stage: capture DQ and strobe the owning requester
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_vld_p[RD_LAT] ? id_onehot(tag_id_p[RD_LAT]) : '0;
      if (tag_vld_p[RD_LAT]) rsp_data <= cs_dq_in;
    end
  end

endmodule

// File: doc/cs_req_scheduler.md
Name: cs_req_scheduler

Overview:
- Front-end controller for the computational storage module.
- Shares the single storage command port between NUM_REQ requesters using round-robin arbitration, and issues at most one command per cycle.
- Returns read data to the requester that issued the read.
- After reset, sequences a memory-clear pass before accepting traffic.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 8, storage address width; DEPTH = 2**ADDR_W
DATA_W, 16, storage data width
RD_LAT, 0, extra cycles from storage read command to valid cs_dq_in (0 = combinational read)
INIT_CLEAR, 1, 1 = write zero to every address after reset release

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  command valid per requester
req_ready  out  NUM_REQ  command accepted this cycle (grant)
req_op  in  2*NUM_REQ  per requester: 0 read, 1 write, 2 add, 3 sub
req_addA  in  ADDR_W*NUM_REQ  source A / read address
req_addB  in  ADDR_W*NUM_REQ  source B address
req_addC  in  ADDR_W*NUM_REQ  destination / write address
req_wdata  in  DATA_W*NUM_REQ  write data
rsp_valid  out  NUM_REQ  one-cycle read-return strobe per requester
rsp_data  out  DATA_W  read data, shared by all requesters
cs_cmd  out  2  storage command
cs_addA  out  ADDR_W  storage address A
cs_addB  out  ADDR_W  storage address B
cs_addC  out  ADDR_W  storage address C
cs_dq_out  out  DATA_W  write data toward the DQ tristate
cs_dq_oe  out  1  DQ drive enable; the top level makes DQ = oe ? dq_out : 'z
cs_dq_in  in  DATA_W  DQ as seen by the controller
busy  out  1  init pass in progress

Behaviour:
- Reset (reset=0, asynchronous):
  - rsp_valid=0, rsp_data=0.
  - cs_cmd=0, all cs_add*=0, cs_dq_out=0, cs_dq_oe=0.
  - rr_ptr=0, tag pipeline cleared.
  - state = INIT if INIT_CLEAR, else RUN.
  - req_ready=0 while reset is asserted.
- FSM INIT:
  - Each cycle, drive cs_cmd=1, cs_addC=cnt, cs_dq_out=0, cs_dq_oe=1; cnt increments from 0.
  - When the write for cnt=DEPTH-1 has been issued, go to RUN.
  - busy=1 and req_ready=0 for exactly DEPTH cycles.
- FSM RUN:
  - busy=0; RUN is left only via reset.
- Arbitration (RUN only):
  - The grant is the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[i]=1 only for that granted i; req_ready is combinational from req_valid and rr_ptr.
  - Accept occurs at edge E when req_valid[i] & req_ready[i]; at that edge rr_ptr <= (i+1) mod NUM_REQ.
  - With no accept, rr_ptr holds.
- Issue (registered at edge E):
  - cs_cmd=req_op[i]; cs_addA, cs_addB, cs_addC are copied unchanged.
  - Write (op 1): cs_dq_out=req_wdata[i], cs_dq_oe=1.
  - All other ops: cs_dq_oe=0, cs_dq_out=0.
  - Back-to-back accepts from any mix of requesters produce no bubbles.
- Idle cycle (no accept):
  - cs_cmd=0 (read is side-effect free), cs_addA/B/C=0, cs_dq_oe=0.
  - Data returned by an idle read is discarded.
- Read return:
  - A tag {valid, id} is shifted through RD_LAT+1 stages.
  - At edge E+1+RD_LAT: rsp_data <= cs_dq_in and rsp_valid[id] <= 1 for one cycle.
  - Other rsp_valid bits are 0. rsp_data holds its last value otherwise.
  - With RD_LAT=0, rsp_valid is high in the cycle after edge E+1.
  - Returns preserve issue order; there is no response backpressure.
- Arithmetic: add/sub are performed inside storage, modulo 2^DATA_W; the controller does no arithmetic.
- Ordering: commands execute in accept order, so a read accepted after a write to the same address returns the new data.
- Reset mid-operation:
  - In-flight tags are dropped; no rsp_valid is produced for them.
  - The init pass restarts from address 0.

Test Plan:
1. Release reset, INIT_CLEAR=1 -> busy=1 for exactly 256 cycles; cs_cmd=1, cs_dq_oe=1, cs_dq_out=0, cs_addC=0..255 in order. Then read addA=0x80 on req0 -> rsp_data=0x0000.
2. req0 write addC=0x10 data 0xBEEF, then read addA=0x10 -> rsp_valid[0] high in the cycle after edge E+1, rsp_data=0xBEEF, rsp_valid[1]=0 throughout.
3. Write mem[1]=0x0005, mem[2]=0x0007; sub addA=1 addB=2 addC=3, read 3 -> 0xFFFE; add into 4, read 4 -> 0x000C. cs_dq_oe=0 during the add/sub cycles.
4. req0 and req1 both hold valid reads to 0x21 and 0x22 (pre-written 0x1111/0x2222) -> grants alternate 0,1,0,1,0,1 starting with req0; each rsp_valid[id] carries its own data.
5. Only req1 valid for 3 cycles -> accepted on 3 consecutive edges; then both valid -> req0 is granted first (rr_ptr=0).
6. Accept a read at E, assert reset before E+1 -> no rsp_valid; all outputs at reset values; busy=1; after release, init restarts at cs_addC=0.
